// File: rtl/dpram_fifo_ctrl.sv
// Single-clock FIFO controller that sequences an external 1-cycle-latency dual-port RAM.
// Optional almost_full/almost_empty outputs are enabled by defining DPRAM_FIFO_THRESH_EN.
module dpram_fifo_ctrl #(
  parameter int ADDR_W        = 10,
  parameter int DATA_W        = 8,
  parameter int AFULL_THRESH  = 1020,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_err,
  output logic              unf_err,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr,
`ifdef DPRAM_FIFO_THRESH_EN
  output logic              almost_full,
  output logic              almost_empty,
`endif
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic full_w, empty_w, push_ok, pop_ok;

  // Flags come from the registered count, so accepted ops show up one edge later.
  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);
  assign push_ok = push & ~full_w & ~flush;
  assign pop_ok  = pop & ~empty_w & ~flush;

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = 1'b0;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
      pop_valid_d = pop_ok;
      ovf_d       = ovf_q | (push & full_w);
      unf_d       = unf_q | (pop & empty_w);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together.
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  // Gating with rst_n keeps the RAM quiet while reset is held, before any edge.
  assign ram_wen     = push_ok & rst_n;
  assign ram_waddr   = wr_ptr_q;
  assign ram_data_in = push_data;
  assign ram_ren     = pop_ok & rst_n;
  assign ram_raddr   = rd_ptr_q;

  assign pop_data  = ram_data_out;
  assign pop_valid = pop_valid_q;
  assign full      = full_w;
  assign empty     = empty_w;
  assign count     = count_q;
  assign ovf_err   = ovf_q;
  assign unf_err   = unf_q;

`ifdef DPRAM_FIFO_THRESH_EN
  assign almost_full  = (count_q >= (ADDR_W+1)'(AFULL_THRESH));
  assign almost_empty = (count_q <= (ADDR_W+1)'(AEMPTY_THRESH));
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Self-checking bench for dpram_fifo_ctrl with a behavioural 1024x8 registered-read RAM.
// Threshold checks are compiled in when DPRAM_FIFO_THRESH_EN is defined.
module tb_dpram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        push = 1'b0;
  logic [7:0]  push_data = 8'h00;
  logic        pop = 1'b0;
  logic        full, pop_valid, empty, ovf_err, unf_err;
  logic [7:0]  pop_data;
  logic [10:0] count;
  logic        ram_wen, ram_ren;
  logic [9:0]  ram_waddr, ram_raddr;
  logic [7:0]  ram_data_in, ram_data_out;
`ifdef DPRAM_FIFO_THRESH_EN
  logic        almost_full, almost_empty;
`endif

  int checks = 0;
  int failures = 0;

  logic       wen_s, ren_s;
  logic [9:0] waddr_s;

  always #5 clk = ~clk;

  dpram_fifo_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .push(push), .push_data(push_data),
    .full(full), .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid),
    .empty(empty), .count(count), .ovf_err(ovf_err), .unf_err(unf_err),
    .ram_wen(ram_wen), .ram_waddr(ram_waddr), .ram_data_in(ram_data_in),
    .ram_ren(ram_ren), .ram_raddr(ram_raddr),
`ifdef DPRAM_FIFO_THRESH_EN
    .almost_full(almost_full), .almost_empty(almost_empty),
`endif
    .ram_data_out(ram_data_out)
  );

  logic [7:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_data_in;
    if (ram_ren) ram_data_out <= mem[ram_raddr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs, sample combinational RAM drive mid-cycle, end 1 time unit after the edge.
  task automatic cyc(input logic p, input logic q, input logic f, input logic [7:0] d);
    push = p; pop = q; flush = f; push_data = d;
    @(negedge clk);
    wen_s = ram_wen; ren_s = ram_ren; waddr_s = ram_waddr;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  typedef struct packed {
    logic        push, pop, flush;
    logic [7:0]  din;
    logic        wen, ren;
    logic [10:0] cnt;
    logic        emp, pv;
    logic [7:0]  pdata;
    logic        unf;
  } vec_t;

  vec_t vecs [0:10];
  logic [7:0] exp5 [0:9];

  initial begin
    // push pop flush din | wen ren cnt empty pv pdata unf
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 11'd2, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b0, 11'd3, 1'b0, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'd2, 1'b0, 1'b1, 8'h11, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'd1, 1'b0, 1'b1, 8'h22, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 8'h33, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b1, 1'b0, 11'd1, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 11'd0, 1'b1, 1'b1, 8'h44, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 11'd0, 1'b1, 1'b0, 8'h00, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_pop_valid", 32'(pop_valid), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_unf", 32'(unf_err), 32'd0);
    check("rst_wen", 32'(ram_wen), 32'd0);
    check("rst_ren", 32'(ram_ren), 32'd0);
    check("rst_waddr", 32'(ram_waddr), 32'd0);
    check("rst_raddr", 32'(ram_raddr), 32'd0);
`ifdef DPRAM_FIFO_THRESH_EN
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_aempty", 32'(almost_empty), 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic order, pop/push on empty, flush with push
    for (int i = 0; i < 11; i++) begin
      cyc(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].din);
      check($sformatf("vec%0d_wen", i), 32'(wen_s), 32'(vecs[i].wen));
      check($sformatf("vec%0d_ren", i), 32'(ren_s), 32'(vecs[i].ren));
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].cnt));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].pv));
      check($sformatf("vec%0d_unf", i), 32'(unf_err), 32'(vecs[i].unf));
      if (vecs[i].pv) check($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(vecs[i].pdata));
    end

    // Fill to 1024 and wrap
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i) ^ 8'h5A);
      if (i == 1023) check("fill_last_waddr", 32'(waddr_s), 32'd1023);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd1024);
    check("fill_ovf_pre", 32'(ovf_err), 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 8'hEE);
    check("ovf_no_wen", 32'(wen_s), 32'd0);
    check("ovf_set", 32'(ovf_err), 32'd1);
    check("ovf_count", 32'(count), 32'd1024);
    cyc(1'b1, 1'b1, 1'b0, 8'hEE);
    check("full_pushpop_wen", 32'(wen_s), 32'd0);
    check("full_pushpop_ren", 32'(ren_s), 32'd1);
    check("full_pushpop_count", 32'(count), 32'd1023);
    check("full_pushpop_data", 32'(pop_data), 32'h5A);
    cyc(1'b1, 1'b0, 1'b0, 8'hA5);
    check("wrap_wen", 32'(wen_s), 32'd1);
    check("wrap_waddr", 32'(waddr_s), 32'd0);
    check("wrap_count", 32'(count), 32'd1024);
    for (int i = 1; i <= 1024; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'h00);
      check($sformatf("drain%0d_valid", i), 32'(pop_valid), 32'd1);
      check($sformatf("drain%0d_data", i), 32'(pop_data),
            (i == 1024) ? 32'hA5 : 32'(8'(i) ^ 8'h5A));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h60 + 8'(i));
      exp5[i] = 8'h60 + 8'(i);
      exp5[i+5] = 8'h70 + 8'(i);
    end
    check("c5_count", 32'(count), 32'd5);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 8'h70 + 8'(i));
      check($sformatf("c5_%0d_count", i), 32'(count), 32'd5);
      check($sformatf("c5_%0d_valid", i), 32'(pop_valid), 32'd1);
      check($sformatf("c5_%0d_data", i), 32'(pop_data), 32'(exp5[i]));
    end

    // Asynchronous reset mid-stream with push and pop pending
    push = 1'b1; pop = 1'b1; push_data = 8'h99;
    #2;
    rst_n = 1'b0;
    #1;
    check("mrst_count", 32'(count), 32'd0);
    check("mrst_empty", 32'(empty), 32'd1);
    check("mrst_pop_valid", 32'(pop_valid), 32'd0);
    check("mrst_wen", 32'(ram_wen), 32'd0);
    check("mrst_ren", 32'(ram_ren), 32'd0);
    @(posedge clk);
    #1;
    check("mrst_hold_pop_valid", 32'(pop_valid), 32'd0);
    push = 1'b0; pop = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_after_pop_valid", 32'(pop_valid), 32'd0);
    check("mrst_after_count", 32'(count), 32'd0);

    // Flush with errors set and a concurrent push
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    check("fl_unf_set", 32'(unf_err), 32'd1);
    for (int i = 0; i < 1024; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 8'(i));
`ifdef DPRAM_FIFO_THRESH_EN
      if (i == 1018) check("afull_1019", 32'(almost_full), 32'd0);
      if (i == 1019) check("afull_1020", 32'(almost_full), 32'd1);
      if (i == 3)    check("aempty_4", 32'(almost_empty), 32'd1);
      if (i == 4)    check("aempty_5", 32'(almost_empty), 32'd0);
`endif
    end
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    check("fl_ovf_set", 32'(ovf_err), 32'd1);
    cyc(1'b1, 1'b1, 1'b1, 8'h77);
    check("fl_no_wen", 32'(wen_s), 32'd0);
    check("fl_no_ren", 32'(ren_s), 32'd0);
    check("fl_count", 32'(count), 32'd0);
    check("fl_empty", 32'(empty), 32'd1);
    check("fl_full", 32'(full), 32'd0);
    check("fl_ovf_clr", 32'(ovf_err), 32'd0);
    check("fl_unf_clr", 32'(unf_err), 32'd0);
    check("fl_pop_valid", 32'(pop_valid), 32'd0);
    check("fl_waddr", 32'(ram_waddr), 32'd0);
    check("fl_raddr", 32'(ram_raddr), 32'd0);
`ifdef DPRAM_FIFO_THRESH_EN
    check("fl_afull", 32'(almost_full), 32'd0);
    check("fl_aempty", 32'(almost_empty), 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Single-clock FIFO controller that sequences one `dpram_1024x8` instance as a 1024-entry, 8-bit first-in-first-out buffer. It owns the write and read pointers, occupancy count and full/empty flags, and drives the RAM's `wen`/`waddr`/`data_in`/`ren`/`raddr` directly. It accounts for the RAM's one-cycle registered read latency. It sits between a producer and a consumer inside the fabric, and both share the same `clk` as the RAM.

## Interface
Parameters:
- `ADDR_W`, 10, RAM address width; depth = 2^ADDR_W.
- `DATA_W`, 8, data width; equals RAM word width.
- `AFULL_THRESH`, 1020, almost-full level; used only with `DPRAM_FIFO_THRESH_EN`.
- `AEMPTY_THRESH`, 4, almost-empty level; used only with `DPRAM_FIFO_THRESH_EN`.

Ports:
- `clk` in 1: the single clock, shared with the RAM.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous clear of all state.
- `push` in 1: write request.
- `push_data` in DATA_W: write data.
- `full` out 1: FIFO holds 2^ADDR_W entries.
- `pop` in 1: read request.
- `pop_data` out DATA_W: read data, valid only when `pop_valid` is high.
- `pop_valid` out 1: `pop_data` is valid this cycle.
- `empty` out 1: FIFO holds 0 entries.
- `count` out ADDR_W+1: current occupancy.
- `ovf_err` out 1: sticky flag, push attempted while full.
- `unf_err` out 1: sticky flag, pop attempted while empty.
- `ram_wen` out 1: to RAM `wen`.
- `ram_waddr` out ADDR_W: to RAM `waddr`.
- `ram_data_in` out DATA_W: to RAM `data_in`.
- `ram_ren` out 1: to RAM `ren`.
- `ram_raddr` out ADDR_W: to RAM `raddr`.
- `ram_data_out` in DATA_W: from RAM `data_out`.
- `almost_full`, `almost_empty` out 1: present only with `DPRAM_FIFO_THRESH_EN`.

## Operation
- **Push acceptance:** `push_ok = push & ~full & ~flush`.
- **Pop acceptance:** `pop_ok = pop & ~empty & ~flush`.
- **RAM write drive:** `ram_wen = push_ok`, `ram_waddr = wr_ptr`, `ram_data_in = push_data`. These are combinational, in the same cycle as the request.
- **RAM read drive:** `ram_ren = pop_ok`, `ram_raddr = rd_ptr`. These are combinational.
- **Pointer update:** `wr_ptr` increments on `push_ok`; `rd_ptr` increments on `pop_ok`. Both are ADDR_W bits and wrap from 2^ADDR_W−1 to 0 with no extra bit.
- **Count update:**
  - `push_ok` only: `count` +1.
  - `pop_ok` only: `count` −1.
  - Both, or neither: `count` unchanged.
- **Flags:** `full = (count == 2^ADDR_W)` and `empty = (count == 0)`. Both are decoded from the registered `count`.
- **Push while full:** the push is refused even if a pop is accepted in the same cycle.
- **Pop while empty:** the pop is refused even if a push is requested in the same cycle. The data becomes poppable the next cycle.
- **Read data path:** `pop_valid` is a register, set to the value of `pop_ok`. `pop_data = ram_data_out` as a passthrough.
- **Error flags:**
  - `ovf_err` sets on `push & full & ~flush`.
  - `unf_err` sets on `pop & empty & ~flush`.
  - Both clear only on reset or `flush`.
- **Flush:** has priority over push and pop. On the next edge it clears pointers, `count`, `pop_valid` and both error flags. RAM contents are not cleared.
- **Reset mid-operation:** all state clears immediately (asynchronous). `ram_wen` and `ram_ren` are forced to 0 while `rst_n` is low. An in-flight pop is lost and `pop_valid` does not assert.

## Timing
- **Reset values:**
  - `full` 0, `empty` 1, `count` 0, `pop_valid` 0.
  - `ovf_err` 0, `unf_err` 0.
  - `ram_wen` 0, `ram_ren` 0.
  - `almost_full` 0, `almost_empty` 1.
  - `ram_waddr`, `ram_raddr` = 0 (pointer values).
  - `pop_data` is unreset RAM output.
- **Read latency:** `pop_ok` in cycle N gives `pop_valid` = 1 with data in cycle N+1.
- **Back-to-back pops:** one word per cycle.
- **Write-to-read:** `push_ok` in cycle N makes `empty` = 0 in N+1. The earliest pop is N+1 and its data appears in N+2.
- **Flag latency:** `full`, `empty` and `count` reflect accepted operations one edge later.
- **Throughput:** one push and one pop per cycle, concurrently.

## Configuration
- **Macro:** `DPRAM_FIFO_THRESH_EN`.
- **Defined:**
  - `almost_full` = (`count` >= `AFULL_THRESH`).
  - `almost_empty` = (`count` <= `AEMPTY_THRESH`).
  - Both are decoded from the registered `count`.
- **Undefined:** both ports and the threshold logic are absent, and the threshold parameters are ignored.

## Test plan
- **Reset:** assert `rst_n` = 0 mid-stream -> `count` 0, `empty` 1, `pop_valid` 0, `ram_wen`/`ram_ren` 0 immediately.
- **Basic order:** push 0x11, 0x22, 0x33, then pop 3 consecutive cycles -> `pop_valid` on cycles 1–3 after the first pop, with data 0x11, 0x22, 0x33; `empty` 1 afterwards.
- **Fill and wrap:**
  - Push 1024 words -> `full` 1, `count` 1024.
  - A further push -> no `ram_wen`, `ovf_err` 1.
  - Pop 1 word and push 0xA5 -> `ram_waddr` 0 (wrap).
  - Drain -> last word 0xA5.
- **Simultaneous push and pop at `count` 5:** hold both for 10 cycles -> `count` stays 5; data order preserved.
- **Simultaneous push and pop while empty:**
  - Cycle N: push accepted, pop refused, `unf_err` 1.
  - Pop at N+1 -> `pop_valid` with pushed data at N+2.
- **Flush with thresholds (`DPRAM_FIFO_THRESH_EN`):**
  - `count` 1020 -> `almost_full` 1.
  - Assert `flush` together with `push` -> `count` 0, `almost_empty` 1, both error flags 0, no write accepted.
